instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  Upstream neighbour of the instruction decoder. Owns the PC and fetches 32-bit words from instruction memory over a req/ack handshake.
//  Holds the current instruction and presents its fields (op, funct, rs, rt, rd, imm16, target26) to the decoder and register file.
//  On retire, computes the next PC from the decoder's jump/branch controls plus the ALU zero flag.
//  One instruction in flight; no delay slot.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  TIMEOUT    16             max cycles in FETCH awaiting imem_ack before fault (>=1)
// PORTS
//  clk          in   1   system clock; all state on rising edge
//  reset        in   1   synchronous, active-high reset
//  imem_req     out  1   fetch request, level, held until ack
//  imem_addr    out  32  word-aligned fetch address (= pc)
//  imem_rdata   in   32  instruction word, valid when imem_ack=1
//  imem_ack     in   1   memory accepts/returns word this cycle
//  retire       in   1   core done with current instr; advance PC
//  stall        in   1   suppress retire this cycle
//  jump         in   1   decoder: J/JAL
//  jumpReg      in   1   decoder: JR
//  branchatall  in   1   decoder: BEQ/BNE
//  bne          in   1   decoder: branch sense inverted
//  alu_zero     in   1   ALU result == 0
//  rs_data      in   32  register rs value (JR target)
//  instr_valid  out  1   instr and field outputs valid
//  instr        out  32  held instruction word
//  op           out  6   instr[31:26] -> decoder Op
//  funct        out  6   instr[5:0]   -> decoder funct
//  rs,rt,rd     out  5   instr[25:21], [20:16], [15:11]
//  imm16        out  16  instr[15:0]
//  target26     out  26  instr[25:0]
//  pc           out  32  address of held instruction
//  pc_plus4     out  32  pc+4; JAL link value
//  fetch_fault  out  1   sticky: fetch timed out
// BEHAVIOUR
//  Reset: pc=RESET_PC, instr=0, instr_valid=0, fetch_fault=0, state=FETCH, timeout count=0; imem_req asserts in the first cycle after reset.
//  FSM states: FETCH, HOLD, FAULT.
//  FETCH: imem_req=1, imem_addr=pc.
//    - imem_ack=1 at an edge: instr<=imem_rdata, instr_valid<=1, count<=0, go HOLD. Zero-wait memory therefore fetches in 1 cycle.
//    - otherwise count++. When count reaches TIMEOUT-1 with no ack: go FAULT.
//  HOLD: imem_req=0; instr and all field outputs are stable.
//    - retire & !stall: pc<=next_pc, instr_valid<=0, go FETCH.
//    - retire & stall: no action; the core must re-assert retire later.
//  FAULT: imem_req=0, instr_valid=0, fetch_fault=1. Only reset exits.
//  retire outside HOLD: ignored.
//  next_pc priority (first match wins):
//    1. jumpReg: {rs_data[31:2],2'b00} (low bits forced to 0)
//    2. jump: {pc_plus4[31:28], target26, 2'b00}
//    3. branchatall & (alu_zero ^ bne): pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00}
//    4. otherwise: pc_plus4
//  Arithmetic: all additions mod 2^32; wrap at 32'hFFFF_FFFC -> 0 is legal, no flag.
//  Field outputs are combinational slices of instr. pc_plus4 = pc + 4, combinational.
//  Reset mid-FETCH: request dropped the following cycle; an ack coinciding with reset is discarded.
//  Controls and alu_zero are sampled only on the retire edge.
// STRUCTURE
//  Shared package/header: FSM state encodings (2-bit), default RESET_PC, and field bit positions (OP_HI/LO, etc.), alongside the existing opcode/funct defines.
//  Sub-module next_pc_logic: combinational; inputs pc_plus4, target26, imm16, rs_data, jump, jumpReg, branchatall, bne, alu_zero; output next_pc. Instantiated once.
//  Top level: FSM, PC register, instr register, timeout counter.
// TESTING
//  1. Reset, zero-wait memory returning 32'h8C08_0004 (LW) -> imem_addr=0 and req the cycle after reset; HOLD with op=6'h23, rt=8, imm16=4, instr_valid=1.
//  2. pc=0x100, BEQ imm16=16'hFFFF, alu_zero=1, retire -> next imem_addr=0x100; same with bne=1 -> 0x104.
//  3. pc=0x0FFF_FFF0, J target26=26'h0000040, retire -> imem_addr=0x0000_0100. JR rs_data=0x203 -> imem_addr=0x200.
//  4. Hold ack low for TIMEOUT cycles -> FAULT, fetch_fault=1, imem_req=0; retire ignored; reset clears fault and refetches RESET_PC.
//  5. retire with stall=1 for 3 cycles, then retire alone -> PC advances exactly once, to pc+4.
//  6. Reset asserted while in FETCH with ack=1 the same cycle -> instr stays 0, instr_valid=0, refetch from RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage and its neighbours.
//   - fetch_state_t : 2-bit FSM encoding for the fetch controller
//   - RESET_PC_DEFAULT : default PC loaded on reset
//   - *_HI/*_LO : bit positions of the instruction fields
//   - OPC_*/FUNCT_* : opcode and funct values shared with the decoder
//   - branch_offset(): sign-extended, word-scaled branch displacement
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_HOLD  = 2'b01,
        ST_FAULT = 2'b10
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instruction field bit positions
    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int TGT_HI   = 25;
    localparam int TGT_LO   = 0;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;

    // Opcode / funct values used by the decoder
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] FUNCT_JR  = 6'h08;

    // Branch displacement: imm16 counts words, sign-extended to 32 bits
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_next_pc_logic.sv
// next_pc_logic: combinational next-PC selection applied on retire.
//   in  pc_plus4, target26, imm16, rs_data  : candidate address sources
//   in  jump, jumpReg, branchatall, bne     : decoder controls
//   in  alu_zero                            : branch condition source
//   out next_pc                             : selected next PC
// Priority: JR, then J/JAL, then taken branch, else sequential.
module next_pc_logic
    import instruction_fetch_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] target26,
    input  logic [15:0] imm16,
    input  logic [31:0] rs_data,
    input  logic        jump,
    input  logic        jumpReg,
    input  logic        branchatall,
    input  logic        bne,
    input  logic        alu_zero,
    output logic [31:0] next_pc
);

    logic        branch_taken;
    logic [31:0] jr_target;
    logic [31:0] j_target;
    logic [31:0] br_target;

    // bne inverts the sense of the zero test
    assign branch_taken = branchatall & (alu_zero ^ bne);
    // A misaligned register target is forced onto a word boundary
    assign jr_target    = rs_data & 32'hFFFF_FFFC;
    assign j_target     = {pc_plus4[31:28], target26, 2'b00};
    assign br_target    = pc_plus4 + branch_offset(imm16);

    always_comb begin
        next_pc = pc_plus4;
        if (jumpReg) begin
            next_pc = jr_target;
        end else if (jump) begin
            next_pc = j_target;
        end else if (branch_taken) begin
            next_pc = br_target;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, fetches one instruction at a time over a
// level req/ack handshake, holds it for the decoder and advances on retire.
//   clk, reset                 : clock, synchronous active-high reset
//   imem_req/addr/rdata/ack    : instruction memory handshake
//   retire, stall              : advance request from the core (stall masks)
//   jump, jumpReg, branchatall, bne, alu_zero, rs_data : next-PC controls
//   instr_valid, instr, op, funct, rs, rt, rd, imm16, target26 : held instr
//   pc, pc_plus4               : address of held instr and its successor
//   fetch_fault                : sticky, memory failed to ack in time
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        retire,
    input  logic        stall,
    input  logic        jump,
    input  logic        jumpReg,
    input  logic        branchatall,
    input  logic        bne,
    input  logic        alu_zero,
    input  logic [31:0] rs_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic [25:0] target26,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_fault
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_t     state_reg, state_next;
    logic [31:0]      pc_reg, pc_next;
    logic [31:0]      instr_reg, instr_next;
    logic             valid_reg, valid_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [31:0]      next_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_FETCH;
            pc_reg    <= RESET_PC;
            instr_reg <= '0;
            valid_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            valid_reg <= valid_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        valid_next = valid_reg;
        count_next = count_reg;
        case (state_reg)
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_next = imem_rdata;
                    valid_next = 1'b1;
                    count_next = '0;
                    state_next = ST_HOLD;
                end else if (count_reg == CNT_LAST) begin
                    valid_next = 1'b0;
                    state_next = ST_FAULT;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            ST_HOLD: begin
                // A stalled retire is dropped, not remembered
                if (retire && !stall) begin
                    pc_next    = next_pc;
                    valid_next = 1'b0;
                    state_next = ST_FETCH;
                end
            end
            ST_FAULT: begin
                valid_next = 1'b0;
            end
            default: begin
                state_next = ST_FAULT;
                valid_next = 1'b0;
            end
        endcase
    end

    next_pc_logic u_next_pc (
        .pc_plus4    (pc_plus4),
        .target26    (target26),
        .imm16       (imm16),
        .rs_data     (rs_data),
        .jump        (jump),
        .jumpReg     (jumpReg),
        .branchatall (branchatall),
        .bne         (bne),
        .alu_zero    (alu_zero),
        .next_pc     (next_pc)
    );

    assign imem_req    = (state_reg == ST_FETCH);
    assign imem_addr   = pc_reg;
    assign fetch_fault = (state_reg == ST_FAULT);
    assign instr_valid = valid_reg;
    assign instr       = instr_reg;
    assign pc          = pc_reg;
    assign pc_plus4    = pc_reg + 32'd4;

    assign op       = instr_reg[OP_HI:OP_LO];
    assign funct    = instr_reg[FUNCT_HI:FUNCT_LO];
    assign rs       = instr_reg[RS_HI:RS_LO];
    assign rt       = instr_reg[RT_HI:RT_LO];
    assign rd       = instr_reg[RD_HI:RD_LO];
    assign imm16    = instr_reg[IMM_HI:IMM_LO];
    assign target26 = instr_reg[TGT_HI:TGT_LO];

endmodule
